// File: rtl/count_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : count_pwm_gen
// Function : PWM generator slaved to an external mod-N counter, with
//            double-buffered duty, period counting and count-continuity check.
// Revision : 1.0
// ============================================================================
module count_pwm_gen #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] count,
    input  logic [W:0]   duty_in,
    input  logic         duty_load,
    input  logic         err_clr,
    output logic         pwm_out,
    output logic         wrap_pulse,
    output logic [15:0]  period_cnt,
    output logic         seq_err,
    output logic         duty_pending
);

    localparam logic [1:0]   c_idle = 2'd0;
    localparam logic [1:0]   c_sync = 2'd1;
    localparam logic [1:0]   c_run  = 2'd2;
    localparam logic [W:0]   c_n    = (W+1)'(N);
    localparam logic [W-1:0] c_last = W'(N - 1);

    logic [1:0]   r_state;
    logic [W-1:0] r_prev_count;
    logic [W:0]   r_shadow;
    logic [W:0]   r_duty_active;
    logic         r_pending;
    logic         r_pwm;
    logic         r_wrap;
    logic [15:0]  r_period_cnt;
    logic         r_seq_err;

    logic [1:0]   w_state_nxt;
    logic         w_start;
    logic         w_err_set;
    logic         w_wrap_nxt;
    logic         w_apply;
    logic [W:0]   w_duty_eff;
    logic [W:0]   w_duty_clamped;
    logic [W-1:0] w_expected;
    logic         w_count_zero;
    logic         w_in_seq;
    logic         w_pwm_nxt;

    assign w_duty_clamped = (duty_in > c_n) ? c_n : duty_in;
    assign w_expected     = (r_prev_count == c_last) ? '0 : r_prev_count + W'(1);
    assign w_count_zero   = (count == '0);
    assign w_in_seq       = (count == w_expected);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_err_set   = 1'b0;
        w_wrap_nxt  = 1'b0;
        if (!en) begin
            w_state_nxt = c_idle;
        end else begin
            case (r_state)
                c_idle: w_state_nxt = c_sync;
                c_sync: begin
                    if (w_count_zero) begin
                        w_state_nxt = c_run;
                        w_start     = 1'b1;
                    end
                end
                c_run: begin
                    if (w_in_seq) begin
                        w_start    = w_count_zero;
                        w_wrap_nxt = w_count_zero;
                    end else begin
                        // Any break in the sequence, including an upstream reset to 0
                        w_err_set   = 1'b1;
                        w_state_nxt = c_sync;
                    end
                end
                default: w_state_nxt = c_idle;
            endcase
        end
    end

    // A pending duty takes effect on the very cycle that starts the period
    assign w_apply    = w_start & r_pending;
    assign w_duty_eff = w_apply ? r_shadow : r_duty_active;
    assign w_pwm_nxt  = (w_state_nxt == c_run) && ({1'b0, count} < w_duty_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_idle;
            r_prev_count  <= '0;
            r_shadow      <= '0;
            r_duty_active <= '0;
            r_pending     <= 1'b0;
            r_pwm         <= 1'b0;
            r_wrap        <= 1'b0;
            r_period_cnt  <= '0;
            r_seq_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_count <= count;
            r_pwm        <= w_pwm_nxt;
            r_wrap       <= w_wrap_nxt;
            if (duty_load) begin
                r_shadow <= w_duty_clamped;
            end
            if (w_apply) begin
                r_duty_active <= r_shadow;
            end
            // A load coinciding with the period start stays pending for the next one
            r_pending <= duty_load | (r_pending & ~w_apply);
            if (w_wrap_nxt && (r_period_cnt != 16'hFFFF)) begin
                r_period_cnt <= r_period_cnt + 16'd1;
            end
            r_seq_err <= w_err_set | (r_seq_err & ~err_clr);
        end
    end

    assign pwm_out      = r_pwm;
    assign wrap_pulse   = r_wrap;
    assign period_cnt   = r_period_cnt;
    assign seq_err      = r_seq_err;
    assign duty_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_count_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_pwm_gen
// Function : Directed scoreboard bench for count_pwm_gen (N=16).
// Revision : 1.0
// ============================================================================
module tb_count_pwm_gen;

    localparam int N = 16;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] count;
    logic [W:0]   duty_in;
    logic         duty_load;
    logic         err_clr;
    logic         pwm_out;
    logic         wrap_pulse;
    logic [15:0]  period_cnt;
    logic         seq_err;
    logic         duty_pending;

    count_pwm_gen #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .count        (count),
        .duty_in      (duty_in),
        .duty_load    (duty_load),
        .err_clr      (err_clr),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse),
        .period_cnt   (period_cnt),
        .seq_err      (seq_err),
        .duty_pending (duty_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pwm;
        logic        wrap;
        logic [15:0] pc;
        logic        err;
        logic        pend;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_cycle  = 0;
    logic [15:0] x_pc     = 16'd0;
    logic        x_err    = 1'b0;
    logic        x_pend   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, n_cycle, act, req);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge after stimulus started
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        n_cycle++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pwm_out",      {31'd0, pwm_out},      {31'd0, e.pwm});
            check("wrap_pulse",   {31'd0, wrap_pulse},   {31'd0, e.wrap});
            check("period_cnt",   {16'd0, period_cnt},   {16'd0, e.pc});
            check("seq_err",      {31'd0, seq_err},      {31'd0, e.err});
            check("duty_pending", {31'd0, duty_pending}, {31'd0, e.pend});
        end
    end

    task automatic step(input logic e, input int c, input logic ld, input int d,
                        input logic clr, input logic xp, input logic xw);
        @(negedge clk);
        en        = e;
        count     = c[W-1:0];
        duty_load = ld;
        duty_in   = d[W:0];
        err_clr   = clr;
        sb.push_back('{xp, xw, x_pc, x_err, x_pend});
    endtask

    // Free-running count in RUN: high while count < duty, wrap at every 0
    task automatic run(input int c0, input int c1, input int duty);
        for (int c = c0; c <= c1; c++) begin
            if (c == 0) x_pc = x_pc + 16'd1;
            step(1'b1, c, 1'b0, 0, 1'b0, (c < duty), (c == 0));
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_pwm"},  {31'd0, pwm_out},      32'd0);
        check({nm, "_wrap"}, {31'd0, wrap_pulse},   32'd0);
        check({nm, "_pc"},   {16'd0, period_cnt},   32'd0);
        check({nm, "_err"},  {31'd0, seq_err},      32'd0);
        check({nm, "_pend"}, {31'd0, duty_pending}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; count = '0; duty_in = '0; duty_load = 1'b0; err_clr = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Duty 4, sync from count 5, then three full periods
        x_pend = 1'b1;
        step(1'b1, 5, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        for (int c = 6; c <= 15; c++) step(1'b1, c, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        x_pend = 1'b0;
        step(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        run(1, 15, 4);
        repeat (3) run(0, 15, 4);

        // Load 12 mid-period: current period keeps 4
        run(0, 6, 4);
        x_pend = 1'b1;
        step(1'b1, 7, 1'b1, 12, 1'b0, 1'b0, 1'b0);
        run(8, 15, 4);
        x_pend = 1'b0;
        run(0, 4, 12);
        x_pend = 1'b1;
        step(1'b1, 5, 1'b1, 2, 1'b0, 1'b1, 1'b0);
        run(6, 15, 12);
        // Load 6 on the period start: period uses 2, 6 stays pending
        x_pc = x_pc + 16'd1;
        step(1'b1, 0, 1'b1, 6, 1'b0, 1'b1, 1'b1);
        run(1, 15, 2);
        x_pend = 1'b0;
        run(0, 15, 6);

        // Clamp 20 -> 16 (always high), then duty 0 (always low, still wraps)
        run(0, 2, 6);
        x_pend = 1'b1;
        step(1'b1, 3, 1'b1, 20, 1'b0, 1'b1, 1'b0);
        run(4, 15, 6);
        x_pend = 1'b0;
        run(0, 2, 16);
        x_pend = 1'b1;
        step(1'b1, 3, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        run(4, 15, 16);
        x_pend = 1'b0;
        run(0, 15, 0);
        run(0, 0, 0);
        x_pend = 1'b1;
        step(1'b1, 1, 1'b1, 8, 1'b0, 1'b0, 1'b0);
        run(2, 15, 0);
        x_pend = 1'b0;
        run(0, 9, 8);

        // Upstream reset 9 -> 0: error, SYNC, no immediate re-entry
        x_err = 1'b1;
        step(1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 15; c++) step(1'b1, c, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        run(1, 4, 8);
        x_err = 1'b0;
        step(1'b1, 5, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        run(6, 15, 8);
        // err_clr together with a new discontinuity keeps the flag
        x_err = 1'b1;
        step(1'b1, 7, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int c = 8; c <= 15; c++) step(1'b1, c, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        x_err = 1'b0;
        step(1'b1, 1, 1'b0, 0, 1'b1, 1'b1, 1'b0);

        // Drop en at count 2, re-raise at 7, resume at next 0
        for (int c = 2; c <= 6; c++) step(1'b0, c, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int c = 7; c <= 15; c++) step(1'b1, c, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        run(1, 15, 8);
        run(0, 3, 8);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        x_pc = 16'd0; x_err = 1'b0; x_pend = 1'b0;
        step(1'b0, 5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 6, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        x_pend = 1'b1;
        step(1'b0, 8, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 9, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int c = 10; c <= 15; c++) step(1'b1, c, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        x_pend = 1'b0;
        step(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        run(1, 15, 5);
        run(0, 1, 5);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
